// File: rtl/lzc_pkg.sv
// Shared helpers and pair-encoder constants for the lzc_pipe leading/trailing-zero counter.
package lzc_pkg;

    localparam logic [1:0] ENC_ZERO = 2'b10;
    localparam logic [1:0] ENC_ONE  = 2'b01;
    localparam logic [1:0] ENC_MSB  = 2'b00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int count_w(input int width);
        return clog2(width) + 1;
    endfunction

    function automatic int stage_count(input int levels, input int levels_per_stage);
        return (levels + levels_per_stage - 1) / levels_per_stage;
    endfunction

endpackage

// File: rtl/lzc_merge.sv
// Merge node of the zero-count tree: combines two K-bit child counts (MSB = all-zero flag).
module lzc_merge #(
    parameter int K = 2
) (
    input  logic [K-1:0] left,
    input  logic [K-1:0] right,
    output logic [K:0]   merged
);

    always_comb begin
        if (left[K-1] && right[K-1]) begin
            merged = {1'b1, {K{1'b0}}};
        end else if (left[K-1]) begin
            merged = {2'b01, right[K-2:0]};
        end else begin
            merged = {1'b0, left};
        end
    end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading/trailing-zero counter with valid/ready on both sides.
// Define LZC_NORMALIZE_EN to add out_norm (input shifted by the count) through one extra stage.
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [count_w(WIDTH)-1:0]  out_count,
    output logic                       out_zero,
`ifdef LZC_NORMALIZE_EN
    output logic [WIDTH-1:0]           out_norm,
`endif
    output logic [TAG_W-1:0]           out_tag
);

    localparam int L  = clog2(WIDTH);
    localparam int CW = count_w(WIDTH);
    localparam int S  = stage_count(L, LEVELS_PER_STAGE);
`ifdef LZC_NORMALIZE_EN
    localparam int NS = S + 1;
`else
    localparam int NS = S;
`endif

    logic [NS-1:0]    vld_q, vld_d, adv_w, ld_w;
    logic [TAG_W-1:0] tag_q [NS];
    logic [TAG_W-1:0] tag_d [NS];
    logic [WIDTH-1:0] scan_w;
    logic [CW-1:0]    cnt_w;

    // Backpressure runs combinationally from out_ready to in_ready; bubbles collapse.
    always_comb begin
        adv_w = '0;
        ld_w  = '0;
        vld_d = vld_q;
        adv_w[NS-1] = vld_q[NS-1] & out_ready;
        for (int s = NS - 2; s >= 0; s--) begin
            adv_w[s] = vld_q[s] & (~vld_q[s+1] | adv_w[s+1]);
        end
        in_ready = ~vld_q[0] | adv_w[0];
        ld_w[0]  = in_valid & in_ready;
        for (int s = 1; s < NS; s++) begin
            ld_w[s] = adv_w[s-1];
        end
        for (int s = 0; s < NS; s++) begin
            vld_d[s] = ld_w[s] | (vld_q[s] & ~adv_w[s]);
        end
    end

    always_comb begin
        tag_d[0] = ld_w[0] ? in_tag : tag_q[0];
        for (int s = 1; s < NS; s++) begin
            tag_d[s] = ld_w[s] ? tag_q[s-1] : tag_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        tag_q <= tag_d;
    end

    // Trailing-zero mode is a leading-zero count of the bit-reversed vector.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            scan_w[i] = in_mode ? in_data[WIDTH-1-i] : in_data[i];
        end
    end

    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int NO = WIDTH >> l;
        localparam int OW = l + 1;
        localparam int SI = (l - 1) / LEVELS_PER_STAGE;
        logic [NO*OW-1:0] comb_w;
        logic [NO*OW-1:0] nxt_w;

        if (l == 1) begin : g_enc
            for (genvar n = 0; n < NO; n++) begin : g_pair
                assign comb_w[2*n +: 2] = scan_w[2*n+1] ? ENC_MSB :
                                          (scan_w[2*n] ? ENC_ONE : ENC_ZERO);
            end
        end else begin : g_mrg
            logic [2*NO*l-1:0] src_w;
            assign src_w = g_lvl[l-1].nxt_w;
            for (genvar n = 0; n < NO; n++) begin : g_node
                lzc_merge #(.K(l)) u_merge (
                    .left   (src_w[(2*n+1)*l +: l]),
                    .right  (src_w[(2*n)*l +: l]),
                    .merged (comb_w[n*OW +: OW])
                );
            end
        end

        if ((l % LEVELS_PER_STAGE == 0) || (l == L)) begin : g_reg
            logic [NO*OW-1:0] lvl_q, lvl_d;
            always_comb lvl_d = ld_w[SI] ? comb_w : lvl_q;
            always_ff @(posedge clk) lvl_q <= lvl_d;
            assign nxt_w = lvl_q;
        end else begin : g_comb
            assign nxt_w = comb_w;
        end
    end

    assign cnt_w = g_lvl[L].nxt_w;

`ifdef LZC_NORMALIZE_EN
    logic [WIDTH-1:0] dat_q [S];
    logic [WIDTH-1:0] dat_d [S];
    logic [S-1:0]     mode_q, mode_d;
    logic [CW-1:0]    ncnt_q, ncnt_d;
    logic [WIDTH-1:0] norm_q, norm_d;

    always_comb begin
        dat_d  = dat_q;
        mode_d = mode_q;
        ncnt_d = ncnt_q;
        norm_d = norm_q;
        if (ld_w[0]) begin
            dat_d[0]  = in_data;
            mode_d[0] = in_mode;
        end
        for (int s = 1; s < S; s++) begin
            if (ld_w[s]) begin
                dat_d[s]  = dat_q[s-1];
                mode_d[s] = mode_q[s-1];
            end
        end
        // An all-zero vector shifts to zero on its own, so no special case is needed.
        if (ld_w[S]) begin
            ncnt_d = cnt_w;
            norm_d = mode_q[S-1] ? (dat_q[S-1] >> cnt_w) : (dat_q[S-1] << cnt_w);
        end
    end

    always_ff @(posedge clk) begin
        dat_q  <= dat_d;
        mode_q <= mode_d;
        ncnt_q <= ncnt_d;
        norm_q <= norm_d;
    end

    assign out_count = vld_q[NS-1] ? ncnt_q : '0;
    assign out_norm  = vld_q[NS-1] ? norm_q : '0;
`else
    assign out_count = vld_q[NS-1] ? cnt_w : '0;
`endif

    // Data registers are not reset; gating with valid gives the idle output values.
    assign out_valid = vld_q[NS-1];
    assign out_zero  = out_count[CW-1];
    assign out_tag   = vld_q[NS-1] ? tag_q[NS-1] : '0;

endmodule
